// File: rtl/result_unloader_if.sv
// Bundle between the result unloader, the shared-memory read port and the capture stream.
// The master drives the memory address and the sample stream. The slave returns read data and out_ready.
interface result_unloader_if #(
    parameter int BANK_W = 3,
    parameter int WORD_W = 2,
    parameter int OUT_W  = 16,
    parameter int IDX_W  = 4
);
    logic [BANK_W-1:0] mem_bank;
    logic [WORD_W-1:0] mem_addr;
    logic [31:0]       mem_rd_data;
    // Valid/ready: a sample transfers on a rising edge where out_valid && out_ready.
    // Once out_valid rises, out_data, out_idx and the address stay fixed until that transfer.
    // out_ready may change freely and has no effect while out_valid is low.
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        output mem_bank, mem_addr, out_valid, out_data, out_idx,
        input  mem_rd_data, out_ready
    );

    modport slave (
        input  mem_bank, mem_addr, out_valid, out_data, out_idx,
        output mem_rd_data, out_ready
    );
endinterface

// File: rtl/result_unloader.sv
// Walks a fixed word window of every shared-memory bank and streams each word out on valid/ready.
// Each word is scaled and saturated to OUT_W bits, and any saturation is flagged stickily.
module result_unloader #(
    parameter int NUM_BANKS      = 8,
    parameter int WORDS_PER_BANK = 4,
    parameter int BASE_WORD      = 2,
    parameter int NUM_WORDS      = 2,
    parameter int DATA_LSB       = 1,
    parameter int OUT_W          = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               abort,
    result_unloader_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               sat_flag,
    output logic [1:0]         state_dbg
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int WORD_W = $clog2(WORDS_PER_BANK);
    localparam int IDX_W  = $clog2(NUM_BANKS * NUM_WORDS);
    localparam int TOP_LSB = DATA_LSB + OUT_W;

    localparam logic [BANK_W-1:0] LAST_BANK  = BANK_W'(NUM_BANKS - 1);
    localparam logic [WORD_W-1:0] FIRST_WORD = WORD_W'(BASE_WORD);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(BASE_WORD + NUM_WORDS - 1);
    localparam logic [OUT_W-1:0]  SAT_POS    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  SAT_NEG    = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BANK_W-1:0] bank;
    logic [WORD_W-1:0] word;
    logic              handshake;
    logic              last_sample;
    logic [OUT_W-1:0]  scaled;
    logic              sat_now;

    assign handshake   = bus.out_valid & bus.out_ready;
    assign last_sample = (bank == LAST_BANK) && (word == LAST_WORD);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_FETCH;
                S_FETCH: state_nxt = S_HOLD;
                S_HOLD:  if (handshake) state_nxt = last_sample ? S_DONE : S_FETCH;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // The address stays on the bus through HOLD so a stalled sample keeps its source visible.
    always_comb begin
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        state_dbg    = state;
        bus.mem_bank = '0;
        bus.mem_addr = '0;
        if (state == S_FETCH || state == S_HOLD) begin
            bus.mem_bank = bank;
            bus.mem_addr = word;
        end
    end

    // Out of range when any bit above the window disagrees with the window's sign bit.
    always_comb begin
        sat_now = 1'b0;
        scaled  = bus.mem_rd_data[DATA_LSB +: OUT_W];
        for (int i = TOP_LSB; i < 32; i++) begin
            if (bus.mem_rd_data[i] != bus.mem_rd_data[TOP_LSB-1]) sat_now = 1'b1;
        end
        if (sat_now) scaled = bus.mem_rd_data[31] ? SAT_NEG : SAT_POS;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bank          <= '0;
            word          <= '0;
            bus.out_idx   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            sat_flag      <= 1'b0;
        end else if (abort) begin
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bank        <= '0;
                        word        <= FIRST_WORD;
                        bus.out_idx <= '0;
                        sat_flag    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    bus.out_data  <= scaled;
                    bus.out_valid <= 1'b1;
                    if (sat_now) sat_flag <= 1'b1;
                end
                S_HOLD: begin
                    if (handshake) begin
                        bus.out_valid <= 1'b0;
                        if (!last_sample) begin
                            bus.out_idx <= bus.out_idx + IDX_W'(1);
                            if (word == LAST_WORD) begin
                                word <= FIRST_WORD;
                                bank <= bank + BANK_W'(1);
                            end else begin
                                word <= word + WORD_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_result_unloader.sv
// Randomized bench for result_unloader.
// A spec-level reference model holds each expected sample with its source address in a queue.
module tb_result_unloader;
    localparam int NB   = 8;
    localparam int BASE = 2;
    localparam int NW   = 2;
    localparam int DLSB = 1;
    localparam int OW   = 16;
    localparam int W    = 25;  // {bank[2:0], word[1:0], idx[3:0], data[15:0]}

    logic       sys_clk;
    logic       sys_rst_n;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       sat_flag;
    logic [1:0] state_dbg;

    result_unloader_if ifc ();

    result_unloader dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .abort     (abort),
        .bus       (ifc),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag),
        .state_dbg (state_dbg)
    );

    logic [31:0] mem [NB][4];
    assign ifc.mem_rd_data = mem[ifc.mem_bank][ifc.mem_addr];

    logic [W-1:0] exp_q[$];
    bit           exp_sat;
    bit           exp_sat_at [NB*NW];
    int           n_cmp;
    int           n_err;
    int           done_cnt;
    int           ready_mode;
    int           stall_idx;
    int           stall_left;
    int           start_idx;
    int           abort_idx;
    bit           start_sent;
    bit           abort_sent;

    // ---------------- clock ----------------
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_out_valid"}, 32'(ifc.out_valid), 0);
        check_eq({tag, "_out_data"},  32'(ifc.out_data), 0);
        check_eq({tag, "_out_idx"},   32'(ifc.out_idx), 0);
        check_eq({tag, "_busy"},      32'(busy), 0);
        check_eq({tag, "_done"},      32'(done), 0);
        check_eq({tag, "_sat_flag"},  32'(sat_flag), 0);
        check_eq({tag, "_mem_bank"},  32'(ifc.mem_bank), 0);
        check_eq({tag, "_mem_addr"},  32'(ifc.mem_addr), 0);
        check_eq({tag, "_state"},     32'(state_dbg), 0);
    endtask

    // ---------------- reference model ----------------
    // Signed view of the word shifted down; anything outside the OW-bit signed range clips.
    function automatic logic [OW-1:0] ref_scale(input logic [31:0] d, output bit sat);
        longint s;
        longint hi;
        longint lo;
        s   = longint'($signed(d));
        s   = s >>> DLSB;
        hi  = (longint'(1) <<< (OW - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
        if (s > hi) begin
            sat = 1'b1;
            return hi[OW-1:0];
        end
        if (s < lo) begin
            sat = 1'b1;
            return lo[OW-1:0];
        end
        return s[OW-1:0];
    endfunction

    task automatic build_expected();
        logic [OW-1:0] v;
        bit            s;
        int            idx;
        exp_q.delete();
        exp_sat = 1'b0;
        idx = 0;
        for (int b = 0; b < NB; b++) begin
            for (int w = BASE; w < BASE + NW; w++) begin
                v = ref_scale(mem[b][w], s);
                exp_sat_at[idx] = s;
                exp_sat = exp_sat | s;
                exp_q.push_back({3'(b), 2'(w), 4'(idx), v});
                idx++;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic fill_pattern();
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 4; w++)
                mem[b][w] = 32'((b * 4 + w) << 9);
    endtask

    task automatic fill_random();
        logic [31:0] r;
        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < 4; w++) begin
                r = $urandom;
                case ($urandom_range(0, 3))
                    0: mem[b][w] = r;
                    1: mem[b][w] = {{15{r[16]}}, r[16:0]};
                    2: mem[b][w] = {16'h0000, r[15:0]};
                    default: mem[b][w] = {{14{r[17]}}, r[17:0]};
                endcase
            end
        end
    endtask

    // One clock: sample after the edge, steer out_ready/start/abort, check the visible sample.
    task automatic cycle();
        logic [W-1:0] f;
        bit           rdy;
        int           fidx;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (done) done_cnt++;
        rdy = (ready_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (ifc.out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_sample", 32'(exp_q.size()), 1);
            end else begin
                f    = exp_q[0];
                fidx = int'(f[19:16]);
                if (fidx == abort_idx && !abort_sent) begin
                    abort      = 1'b1;
                    abort_sent = 1'b1;
                    rdy        = 1'b0;
                end else if (fidx == stall_idx && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
                if (fidx == start_idx && !start_sent) begin
                    start      = 1'b1;
                    start_sent = 1'b1;
                end
                check_eq("out_data", 32'(ifc.out_data), 32'(f[15:0]));
                check_eq("mem_bank", 32'(ifc.mem_bank), 32'(f[24:22]));
                check_eq("mem_addr", 32'(ifc.mem_addr), 32'(f[21:20]));
                if (rdy) begin
                    check_eq("out_idx", 32'(ifc.out_idx), 32'(f[19:16]));
                    void'(exp_q.pop_front());
                end
            end
        end
        ifc.out_ready = rdy;
    endtask

    task automatic run_pass(input int mode, input int st_idx, input int sr_idx,
                            input int ab_idx, input int exp_lat);
        int n;
        bit fin;
        bit ab;
        bit sat_prefix;
        ready_mode = mode;
        stall_idx  = st_idx;
        stall_left = 5;
        start_idx  = sr_idx;
        start_sent = 1'b0;
        abort_idx  = ab_idx;
        abort_sent = 1'b0;
        done_cnt   = 0;
        build_expected();
        start = 1'b1;
        cycle();
        check_eq("busy_after_start", 32'(busy), 1);
        n   = 0;
        fin = 1'b0;
        ab  = 1'b0;
        while (!fin && n < 400) begin
            ab = abort_sent;
            cycle();
            n++;
            if (ab || done) fin = 1'b1;
        end
        check_eq("pass_in_budget", 32'(fin), 1);
        if (ab) begin
            check_eq("abort_valid", 32'(ifc.out_valid), 0);
            check_eq("abort_busy", 32'(busy), 0);
            check_eq("abort_done", 32'(done), 0);
            check_eq("abort_state", 32'(state_dbg), 0);
            sat_prefix = 1'b0;
            for (int i = 0; i <= ab_idx; i++) sat_prefix = sat_prefix | exp_sat_at[i];
            repeat (3) cycle();
            check_eq("abort_no_done", 32'(done_cnt), 0);
            check_eq("abort_sat_kept", 32'(sat_flag), 32'(sat_prefix));
            exp_q.delete();
        end else begin
            if (exp_lat >= 0) check_eq("done_latency", 32'(n), 32'(exp_lat));
            repeat (3) cycle();
            check_eq("done_count", 32'(done_cnt), 1);
            check_eq("samples_left", 32'(exp_q.size()), 0);
            check_eq("sat_flag", 32'(sat_flag), 32'(exp_sat));
            check_eq("idle_busy", 32'(busy), 0);
            check_eq("idle_valid", 32'(ifc.out_valid), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        done_cnt = 0;
        start = 1'b0;
        abort = 1'b0;
        ifc.out_ready = 1'b0;
        ready_mode = 0;
        stall_idx = -1;
        stall_left = 0;
        start_idx = -1;
        abort_idx = -1;
        start_sent = 1'b0;
        abort_sent = 1'b0;
        fill_pattern();
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        check_all_zero("reset");

        // start and abort together in IDLE: no pass begins
        start = 1'b1;
        abort = 1'b1;
        cycle();
        check_eq("start_abort_busy", 32'(busy), 0);
        check_eq("start_abort_state", 32'(state_dbg), 0);
        repeat (2) cycle();
        check_eq("start_abort_valid", 32'(ifc.out_valid), 0);

        // ramp pattern, full-rate consumer
        fill_pattern();
        run_pass(0, -1, -1, -1, 32);
        // five-cycle stall on sample 3
        run_pass(0, 3, -1, -1, 37);
        // saturation corners
        fill_pattern();
        mem[0][2] = 32'h0002_0000;
        mem[0][3] = 32'hFFFE_0000;
        mem[1][2] = 32'hFFFF_FFFE;
        run_pass(0, -1, -1, -1, 32);
        check_eq("sat_set", 32'(sat_flag), 1);
        // second start during sample 5, random ready; sat_flag must clear on start
        fill_pattern();
        run_pass(1, -1, 5, -1, -1);
        // abort during sample 7, then a full clean pass
        fill_random();
        run_pass(1, -1, -1, 7, -1);
        run_pass(0, -1, -1, -1, 32);
        // random passes
        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_pass(1, int'($urandom_range(0, 15)), -1, -1, -1);
        end

        // reset in the middle of a pass
        fill_random();
        ready_mode = 1;
        stall_idx = -1;
        start_idx = -1;
        abort_idx = -1;
        build_expected();
        start = 1'b1;
        cycle();
        repeat (9) cycle();
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        exp_q.delete();
        done_cnt = 0;
        repeat (3) cycle();
        check_eq("post_reset_busy", 32'(busy), 0);
        check_eq("post_reset_valid", 32'(ifc.out_valid), 0);
        check_eq("post_reset_state", 32'(state_dbg), 0);
        check_eq("post_reset_done", 32'(done_cnt), 0);
        fill_pattern();
        run_pass(0, -1, -1, -1, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global timeout so the run always ends
    initial begin
        #2000000;
        n_cmp++;
        n_err++;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
